// File: rtl/seg7_scan_if.sv
// seg7_scan_if: display-side bus between a hex producer and the scanned 7-segment driver.
// Producer (master) drives data, dp_in, blank, blink_en, lz_en and load.
// Driver (slave) returns seg, dp, an and frame_done.
interface seg7_scan_if #(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] data;
    logic [DIGITS-1:0]   dp_in;
    logic [DIGITS-1:0]   blank;
    logic [DIGITS-1:0]   blink_en;
    logic                lz_en;
    logic                load;
    logic [6:0]          seg;
    logic                dp;
    logic [DIGITS-1:0]   an;
    logic                frame_done;

    modport master (
        output data, dp_in, blank, blink_en, lz_en, load,
        input  seg, dp, an, frame_done
    );

    modport slave (
        input  data, dp_in, blank, blink_en, lz_en, load,
        output seg, dp, an, frame_done
    );
endinterface

// File: rtl/seg7_scan.sv
// seg7_scan: time-multiplexed DIGITS-wide hex display driver with blanking, blink and zero suppression.
// Ports: clk, rst (sync, active high); bus (seg7_scan_if.slave):
//   in  data/dp_in/blank/blink_en (captured on load), lz_en (live), load
//   out seg (g..a), dp, an (registered, ACTIVE_LOW polarity), frame_done (active-high pulse)
module seg7_scan #(
    parameter int DIGITS     = 4,
    parameter int DIV_W      = 16,
    parameter int BLINK_W    = 6,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input logic clk,
    input logic rst,
    seg7_scan_if.slave bus
);
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);
    localparam logic [6:0] GLYPH [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0100111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
    };

    logic [DIV_W-1:0]    pre;
    logic [IW-1:0]       idx;
    logic [BLINK_W-1:0]  blk;
    logic [4*DIGITS-1:0] sh_data;
    logic [DIGITS-1:0]   sh_dp, sh_blank, sh_blink, an_on;
    logic [3:0]          nib;
    logic                tc, wrap, z, sup, dark;

    assign tc   = &pre;
    assign wrap = tc && idx == LAST;

    // Walk nibbles from the top: z stays 1 while every nibble from DIGITS-1 down to j is zero,
    // so the value of z at the current index tells whether that digit is a leading zero.
    always_comb begin
        nib = '0;
        sup = 1'b0;
        z = 1'b1;
        for (int j = DIGITS - 1; j >= 0; j--) begin
            z = z & (sh_data[4*j +: 4] == 4'd0);
            nib = (IW'(j) == idx) ? sh_data[4*j +: 4] : nib;
            sup = (IW'(j) == idx && j > 0) ? z : sup;
        end
        sup = sup & bus.lz_en;
        dark = sh_blank[idx] | (sh_blink[idx] & blk[BLINK_W-1]) | sup;
        an_on = '0;
        an_on[idx] = 1'b1;
    end

    // Outputs are computed from the pre-edge index and shadow, so a load on any edge
    // (terminal count included) only affects the display from the following edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre            <= '0;
            idx            <= '0;
            blk            <= '0;
            sh_data        <= '0;
            sh_dp          <= '0;
            sh_blank       <= '0;
            sh_blink       <= '0;
            bus.seg        <= {7{ACTIVE_LOW}};
            bus.dp         <= ACTIVE_LOW;
            bus.an         <= {DIGITS{ACTIVE_LOW}};
            bus.frame_done <= 1'b0;
        end else begin
            pre            <= pre + DIV_W'(1);
            idx            <= tc ? (wrap ? '0 : idx + IW'(1)) : idx;
            blk            <= blk + BLINK_W'(wrap);
            bus.frame_done <= wrap;
            if (bus.load) begin
                sh_data  <= bus.data;
                sh_dp    <= bus.dp_in;
                sh_blank <= bus.blank;
                sh_blink <= bus.blink_en;
            end
            bus.seg <= (dark ? 7'd0 : GLYPH[nib]) ^ {7{ACTIVE_LOW}};
            bus.dp  <= (sh_dp[idx] & ~dark) ^ ACTIVE_LOW;
            bus.an  <= an_on ^ {DIGITS{ACTIVE_LOW}};
        end
    end
endmodule

// File: doc/seg7_scan.md
Name: seg7_scan

Overview:
- Parametrised successor to the single-digit hex-to-7-segment decoder.
- Drives a DIGITS-wide, time-multiplexed common-segment display from one packed hex word.
- Adds a refresh prescaler, digit scanning, per-digit blanking, decimal point and blink, leading-zero suppression, and selectable output polarity.
- Sits between the datapath result registers and the board display pins.

Parameters:
DIGITS, 4, number of digits scanned (1..8)
DIV_W, 16, prescaler width; a digit advances every 2^DIV_W clocks
BLINK_W, 6, blink counter width in frames; blink phase = counter MSB
ACTIVE_LOW, 1, 1: seg/dp/an asserted low; 0: asserted high

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
data  in  4*DIGITS  hex nibbles; nibble i (bits 4i+3:4i) is digit i; digit 0 is rightmost
dp_in  in  DIGITS  decimal point request per digit
blank  in  DIGITS  force digit i dark
blink_en  in  DIGITS  digit i dark during the blink-off phase
lz_en  in  1  enable leading-zero suppression
load  in  1  capture data/dp_in/blank/blink_en into the shadow registers
seg  out  7  segments g..a (bit6 = g, bit0 = a)
dp  out  1  decimal point segment
an  out  DIGITS  digit enables, one-hot when a digit is lit
frame_done  out  1  one-cycle pulse when the scan wraps from digit DIGITS-1 to 0

Behaviour:
- Reset (synchronous, rst high at a clk edge):
  - Prescaler, digit index, blink counter and shadow registers cleared to 0.
  - Outputs inactive: all seg, dp and an deasserted (all 1s when ACTIVE_LOW=1); frame_done = 0.
  - rst overrides load and scanning in the same cycle. Reset mid-scan restarts at digit 0 with the prescaler at 0.
- Shadow capture:
  - load=1 captures the inputs at that edge. Scanning always uses the shadow registers, never the live inputs.
  - If load coincides with a prescaler terminal count, the output produced at that edge uses the pre-load shadow; the new values are used from the next edge.
- Prescaler: free-running DIV_W-bit up-counter that wraps at 2^DIV_W-1. Terminal count (all 1s) advances the digit index.
- Digit index:
  - Range 0..DIGITS-1. At DIGITS-1 with terminal count, it wraps to 0 and frame_done pulses for exactly that one cycle.
  - With DIGITS=1 the index stays 0 and frame_done pulses on every terminal count.
- Blink counter: BLINK_W bits, incremented on every frame_done, wraps naturally. Blink-off phase = MSB is 1.
- Glyph table, active-high segment pattern g..a before polarity:
  0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0100111, 8=1111111, 9=1101111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001.
- Digit dark condition for current index i: blank[i]; OR (blink_en[i] AND blink phase off); OR suppressed.
- Suppressed: lz_en=1, i>0, and nibbles DIGITS-1 down to i are all zero. Digit 0 is never suppressed, so value 0 shows a single "0".
- Dark digit: its an stays asserted, seg and dp are deasserted. A blank digit still occupies its time slot so brightness stays uniform.
- dp is asserted when dp_in[i]=1 and the digit is not dark.
- Output timing:
  - seg, dp and an are registered and computed each clk from the current index and shadow state.
  - They reflect a new index one clk after the index register changes.
  - an is exactly one-hot (in asserted polarity) after the first post-reset clk.
- Polarity: ACTIVE_LOW=1 inverts seg, dp and an at the output register. frame_done is always active-high.

Test Plan:
- DIGITS=4, DIV_W=2, load data=16'h12AF, dp_in=0 -> an cycles digits 0,1,2,3 every 4 clks. seg (ACTIVE_LOW) = 0001110 (F), 0001000 (A), 0100100 (2), 1111001 (1). frame_done pulses once per 16 clks.
- Assert rst mid-scan at digit 2 -> next edge gives seg=7'h7F, an=4'hF, dp=1, frame_done=0. Scanning then restarts at digit 0 after 4 clks.
- lz_en=1, data=16'h0040 -> digits 3 and 2 dark with an still asserted. Digit 1 shows 4 (0011001), digit 0 shows 0 (1000000). data=0 -> only digit 0 lit showing "0".
- blink_en=4'b0001, BLINK_W=2 -> digit 0 lit for 2 frames, dark for 2 frames, repeating. Other digits are unaffected.
- Change data without load -> display unchanged. Pulse load on a terminal-count edge -> the old value is shown at that edge and the new value from the next digit slot.
- dp_in=4'b0100 with blank=4'b0100 -> dp stays deasserted. With blank=0 -> dp=0 (asserted) only while an selects digit 2.
